plot_arbiter: RTL

//  Parametrised N-client pixel arbiter feeding the single vga_adapter plot port.

---
 rtl/plot_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/plot_arbiter.sv
// Round-robin pixel arbiter with a priority full-screen clear sweep, driving the vga_adapter plot port.
// Optional: define PLOT_CLIP_EN to consume but not plot client pixels outside X_MAX/Y_MAX.
module plot_arbiter #(
    parameter int N_CLIENTS = 2,
    parameter int GID_W     = 1,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int C_W       = 3,
    parameter int X_MAX     = 319,
    parameter int Y_MAX     = 239
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CLIENTS-1:0]     req_valid,
    output logic [N_CLIENTS-1:0]     req_ready,
    input  logic [N_CLIENTS*X_W-1:0] req_x,
    input  logic [N_CLIENTS*Y_W-1:0] req_y,
    input  logic [N_CLIENTS*C_W-1:0] req_colour,
    input  logic                     clear_req,
    input  logic [C_W-1:0]           clear_colour,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [C_W-1:0]           vga_colour,
    output logic                     vga_plot,
    output logic [GID_W-1:0]         grant_id,
    output logic                     busy
);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t           state, state_next;
    logic [GID_W-1:0] rr_ptr;
    logic [X_W-1:0]   cx;
    logic [Y_W-1:0]   cy;
    logic [C_W-1:0]   clr_col;

    logic             hit;
    logic [GID_W-1:0] sel;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_c;
    logic             plot_en;
    logic             sweep_done;

    function automatic int unsigned wrap_idx(input int unsigned p, input int unsigned k);
        return (p + k) % N_CLIENTS;
    endfunction

    assign sweep_done = (cx == X_W'(X_MAX)) && (cy == Y_W'(Y_MAX));
    assign busy       = (state == CLEAR);

    always_comb begin
        state_next = state;
        req_ready  = '0;
        hit        = 1'b0;
        sel        = '0;
        sel_x      = '0;
        sel_y      = '0;
        sel_c      = '0;
        case (state)
            ARB: begin
                if (clear_req) begin
                    state_next = CLEAR;
                end else begin
                    // First valid client at or after rr_ptr, in wrap-around order.
                    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
                        if (!hit && req_valid[wrap_idx(32'(rr_ptr), k)]) begin
                            hit   = 1'b1;
                            sel   = GID_W'(wrap_idx(32'(rr_ptr), k));
                            sel_x = req_x[wrap_idx(32'(rr_ptr), k)*X_W +: X_W];
                            sel_y = req_y[wrap_idx(32'(rr_ptr), k)*Y_W +: Y_W];
                            sel_c = req_colour[wrap_idx(32'(rr_ptr), k)*C_W +: C_W];
                            req_ready[wrap_idx(32'(rr_ptr), k)] = 1'b1;
                        end
                    end
                end
            end
            CLEAR: begin
                if (sweep_done) state_next = ARB;
            end
            default: state_next = ARB;
        endcase
        // No handshake may complete while reset is held.
        if (reset) req_ready = '0;
    end

`ifdef PLOT_CLIP_EN
    assign plot_en = (sel_x <= X_W'(X_MAX)) && (sel_y <= Y_W'(Y_MAX));
`else
    assign plot_en = 1'b1;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            rr_ptr     <= '0;
            cx         <= '0;
            cy         <= '0;
            clr_col    <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            grant_id   <= '0;
        end else begin
            state <= state_next;
            case (state)
                ARB: begin
                    if (clear_req) begin
                        cx       <= '0;
                        cy       <= '0;
                        clr_col  <= clear_colour;
                        vga_plot <= 1'b0;
                    end else if (hit) begin
                        vga_x      <= sel_x;
                        vga_y      <= sel_y;
                        vga_colour <= sel_c;
                        vga_plot   <= plot_en;
                        grant_id   <= sel;
                        rr_ptr     <= (32'(sel) == 32'(N_CLIENTS - 1)) ? '0 : sel + 1'b1;
                    end else begin
                        vga_plot <= 1'b0;
                    end
                end
                CLEAR: begin
                    vga_x      <= cx;
                    vga_y      <= cy;
                    vga_colour <= clr_col;
                    vga_plot   <= 1'b1;
                    grant_id   <= '0;
                    if (cx == X_W'(X_MAX)) begin
                        cx <= '0;
                        if (!sweep_done) cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                default: vga_plot <= 1'b0;
            endcase
        end
    end

endmodule
